// File: rtl/prf_writeback_arbiter.sv
// Purpose: grants up to two of NUM_REQ writeback requesters per cycle onto the two PRF write ports.
// Latency: grant is combinational; write/ready-set outputs are registered one cycle later.
// Backpressure: wb_stall or flush withholds all grants; requesters hold valid/data until granted.
module prf_writeback_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int XLEN          = 32,
  parameter int PHYS_REG_BITS = 6,
  parameter int PTR_BITS      = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             wb_stall,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*PHYS_REG_BITS-1:0] req_addr,
  input  logic [NUM_REQ*XLEN-1:0]          req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             wr_en1,
  output logic                             wr_en2,
  output logic [PHYS_REG_BITS-1:0]         wr_addr1,
  output logic [PHYS_REG_BITS-1:0]         wr_addr2,
  output logic [XLEN-1:0]                  wr_data1,
  output logic [XLEN-1:0]                  wr_data2,
  output logic                             rdy_set1,
  output logic                             rdy_set2,
  output logic [PHYS_REG_BITS-1:0]         rdy_addr1,
  output logic [PHYS_REG_BITS-1:0]         rdy_addr2,
  output logic [PTR_BITS-1:0]              rr_ptr,
  output logic                             dup_err
);

  logic [PHYS_REG_BITS-1:0] addr_arr [NUM_REQ];
  logic [XLEN-1:0]          data_arr [NUM_REQ];

  logic                g1_found, g2_found;
  logic [PTR_BITS-1:0] g1_idx, g2_idx;
  logic                grant_ok, dup_hit, gnt1, gnt2;
  logic [PTR_BITS-1:0] last_idx, ptr_next;
  int                  scan_idx;
  logic [PTR_BITS-1:0] scan_sel;

  // Unpack the flat requester buses into per-requester slices.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_addr[i*PHYS_REG_BITS +: PHYS_REG_BITS];
      data_arr[i] = req_data[i*XLEN +: XLEN];
    end
  end

  // Circular scan from rr_ptr: first valid requester is G1, second is G2.
  always_comb begin
    g1_found = 1'b0;
    g2_found = 1'b0;
    g1_idx   = '0;
    g2_idx   = '0;
    scan_idx = 0;
    scan_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      scan_sel = scan_idx[PTR_BITS-1:0];
      if (req_valid[scan_sel]) begin
        if (!g1_found) begin
          g1_found = 1'b1;
          g1_idx   = scan_sel;
        end else if (!g2_found) begin
          g2_found = 1'b1;
          g2_idx   = scan_sel;
        end
      end
    end
  end

  // Qualify grants with reset/flush/stall, drop G2 on an address collision, derive next pointer.
  always_comb begin
    grant_ok  = rst_n && !flush && !wb_stall;
    dup_hit   = g1_found && g2_found && (addr_arr[g2_idx] == addr_arr[g1_idx]);
    gnt1      = grant_ok && g1_found;
    gnt2      = grant_ok && g2_found && !dup_hit;
    req_ready = '0;
    if (gnt1) req_ready[g1_idx] = 1'b1;
    if (gnt2) req_ready[g2_idx] = 1'b1;
    last_idx  = gnt2 ? g2_idx : g1_idx;
    ptr_next  = (last_idx == PTR_BITS'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
  end

  // Output stage: register granted writes; ungranted ports keep address/data, drop enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en1   <= 1'b0;
      wr_en2   <= 1'b0;
      wr_addr1 <= '0;
      wr_addr2 <= '0;
      wr_data1 <= '0;
      wr_data2 <= '0;
      rr_ptr   <= '0;
      dup_err  <= 1'b0;
    end else begin
      wr_en1 <= gnt1;
      wr_en2 <= gnt2;
      if (gnt1) begin
        wr_addr1 <= addr_arr[g1_idx];
        wr_data1 <= data_arr[g1_idx];
      end
      if (gnt2) begin
        wr_addr2 <= addr_arr[g2_idx];
        wr_data2 <= data_arr[g2_idx];
      end
      if (gnt1) rr_ptr <= ptr_next;
      if (gnt1 && dup_hit) dup_err <= 1'b1;
    end
  end

  assign rdy_set1  = wr_en1;
  assign rdy_set2  = wr_en2;
  assign rdy_addr1 = wr_addr1;
  assign rdy_addr2 = wr_addr2;

endmodule

// File: tb/tb_prf_writeback_arbiter.sv
// Purpose: self-checking bench for prf_writeback_arbiter (vector table + output scoreboard).
// Latency: checks req_ready in-cycle and registered outputs one cycle later.
// Backpressure: exercises flush and wb_stall cycles inside the vector table.
module tb_prf_writeback_arbiter;

  localparam int NR = 4;
  localparam int XL = 32;
  localparam int AB = 6;
  localparam int PB = 2;
  localparam int NV = 19;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           flush, wb_stall;
  logic [NR-1:0]  req_valid;
  logic [NR*AB-1:0] req_addr;
  logic [NR*XL-1:0] req_data;
  logic [NR-1:0]  req_ready;
  logic           wr_en1, wr_en2, rdy_set1, rdy_set2, dup_err;
  logic [AB-1:0]  wr_addr1, wr_addr2, rdy_addr1, rdy_addr2;
  logic [XL-1:0]  wr_data1, wr_data2;
  logic [PB-1:0]  rr_ptr;

  prf_writeback_arbiter #(.NUM_REQ(NR), .XLEN(XL), .PHYS_REG_BITS(AB), .PTR_BITS(PB)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wb_stall(wb_stall),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .wr_en1(wr_en1), .wr_en2(wr_en2), .wr_addr1(wr_addr1), .wr_addr2(wr_addr2),
    .wr_data1(wr_data1), .wr_data2(wr_data2), .rdy_set1(rdy_set1), .rdy_set2(rdy_set2),
    .rdy_addr1(rdy_addr1), .rdy_addr2(rdy_addr2), .rr_ptr(rr_ptr), .dup_err(dup_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          fl;
    logic          st;
    logic [NR-1:0] vld;
    int            same_addr;  // >=0: every requester targets this address
    logic [NR-1:0] exp_rdy;
    int            g1;         // expected port-1 requester, -1 none
    int            g2;         // expected port-2 requester, -1 none
    logic [PB-1:0] exp_ptr;    // rr_ptr after the edge
    logic          sup;        // G2 suppressed as a duplicate
  } vec_t;

  typedef struct {
    logic          en1;
    logic [AB-1:0] a1;
    logic [XL-1:0] d1;
    logic          en2;
    logic [AB-1:0] a2;
    logic [XL-1:0] d2;
    logic [PB-1:0] ptr;
    logic          de;
  } exp_t;

  vec_t          tbl [NV];
  exp_t          sb [$];
  logic [AB-1:0] a [NR];
  logic [XL-1:0] d [NR];
  logic [AB-1:0] m_a1, m_a2;
  logic [XL-1:0] m_d1, m_d2;
  logic          m_de;
  int            tests = 0;
  int            fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bus();
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AB +: AB] = a[i];
      req_data[i*XL +: XL] = d[i];
    end
  endtask

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    chk("wr_en1", 64'(wr_en1), 64'(e.en1));
    chk("wr_addr1", 64'(wr_addr1), 64'(e.a1));
    chk("wr_data1", 64'(wr_data1), 64'(e.d1));
    chk("wr_en2", 64'(wr_en2), 64'(e.en2));
    chk("wr_addr2", 64'(wr_addr2), 64'(e.a2));
    chk("wr_data2", 64'(wr_data2), 64'(e.d2));
    chk("rdy_set1", 64'(rdy_set1), 64'(e.en1));
    chk("rdy_set2", 64'(rdy_set2), 64'(e.en2));
    chk("rdy_addr1", 64'(rdy_addr1), 64'(e.a1));
    chk("rdy_addr2", 64'(rdy_addr2), 64'(e.a2));
    chk("rr_ptr", 64'(rr_ptr), 64'(e.ptr));
    chk("dup_err", 64'(dup_err), 64'(e.de));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    //            fl st vld      same exp_rdy  g1  g2  ptr  sup
    tbl[0]  = '{1'b0, 1'b0, 4'b0100, 40, 4'b0100,  2, -1, 2'd3, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 4'b1111, -1, 4'b1001,  3,  0, 2'd1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 4'b1111, -1, 4'b0110,  1,  2, 2'd3, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 4'b1001, -1, 4'b1001,  3,  0, 2'd1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 4'b1111, -1, 4'b0110,  1,  2, 2'd3, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'b1111, -1, 4'b1001,  3,  0, 2'd1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 4'b1000, -1, 4'b1000,  3, -1, 2'd0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 4'b1111, -1, 4'b0011,  0,  1, 2'd2, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 4'b1111, -1, 4'b1100,  2,  3, 2'd0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 4'b1111, -1, 4'b0011,  0,  1, 2'd2, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 4'b1111, -1, 4'b0000, -1, -1, 2'd2, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 4'b1111, -1, 4'b0000, -1, -1, 2'd2, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 4'b1111, -1, 4'b1100,  2,  3, 2'd0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 4'b0000, -1, 4'b0000, -1, -1, 2'd0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 4'b0011, 33, 4'b0001,  0, -1, 2'd1, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 4'b0110,  0, 4'b0010,  1, -1, 2'd2, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 4'b1010, -1, 4'b1010,  3,  1, 2'd2, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 4'b0101, -1, 4'b0101,  2,  0, 2'd1, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 4'b1111, -1, 4'b0000, -1, -1, 2'd1, 1'b0};

    // Reset with all requesters valid: nothing granted, outputs cleared.
    rst_n = 1'b0; flush = 1'b0; wb_stall = 1'b0; req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) begin a[i] = AB'(i + 1); d[i] = $urandom; end
    drive_bus();
    repeat (3) @(negedge clk);
    chk("reset req_ready", 64'(req_ready), 64'd0);
    chk("reset wr_en1", 64'(wr_en1), 64'd0);
    chk("reset wr_en2", 64'(wr_en2), 64'd0);
    chk("reset rr_ptr", 64'(rr_ptr), 64'd0);
    chk("reset dup_err", 64'(dup_err), 64'd0);
    req_valid = '0;
    rst_n = 1'b1;
    m_a1 = '0; m_a2 = '0; m_d1 = '0; m_d2 = '0; m_de = 1'b0;

    // Vector table: pointer state carries from one entry to the next.
    for (int v = 0; v < NV; v++) begin
      @(negedge clk);
      if (sb.size() > 0) check_out();
      flush = tbl[v].fl;
      wb_stall = tbl[v].st;
      req_valid = tbl[v].vld;
      for (int i = 0; i < NR; i++) begin
        a[i] = (tbl[v].same_addr >= 0) ? AB'(tbl[v].same_addr) : AB'((3*v + 13*i + 5) % 64);
        d[i] = $urandom;
      end
      drive_bus();
      #1;
      chk($sformatf("req_ready v%0d", v), 64'(req_ready), 64'(tbl[v].exp_rdy));
      if (tbl[v].g1 >= 0) begin m_a1 = a[tbl[v].g1]; m_d1 = d[tbl[v].g1]; end
      if (tbl[v].g2 >= 0) begin m_a2 = a[tbl[v].g2]; m_d2 = d[tbl[v].g2]; end
      if (tbl[v].sup) m_de = 1'b1;
      e.en1 = (tbl[v].g1 >= 0); e.a1 = m_a1; e.d1 = m_d1;
      e.en2 = (tbl[v].g2 >= 0); e.a2 = m_a2; e.d2 = m_d2;
      e.ptr = tbl[v].exp_ptr; e.de = m_de;
      sb.push_back(e);
    end
    @(negedge clk);
    check_out();
    flush = 1'b0; wb_stall = 1'b0; req_valid = 4'b1111;

    // Asynchronous reset mid-operation clears state and the sticky dup flag at once.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async rst wr_en1", 64'(wr_en1), 64'd0);
    chk("async rst rr_ptr", 64'(rr_ptr), 64'd0);
    chk("async rst dup_err", 64'(dup_err), 64'd0);
    chk("async rst req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request on requester 2 lands on port 1.
    req_valid = 4'b0100;
    a[2] = AB'(40); d[2] = 32'hDEADBEEF;
    drive_bus();
    #1 chk("single req_ready", 64'(req_ready), 64'b0100);
    @(negedge clk);
    chk("single wr_en1", 64'(wr_en1), 64'd1);
    chk("single wr_addr1", 64'(wr_addr1), 64'd40);
    chk("single wr_data1", 64'(wr_data1), 64'hDEADBEEF);
    chk("single rdy_set1", 64'(rdy_set1), 64'd1);
    chk("single wr_en2", 64'(wr_en2), 64'd0);
    chk("single rr_ptr", 64'(rr_ptr), 64'd3);
    req_valid = '0;
    @(negedge clk);
    chk("idle wr_en1", 64'(wr_en1), 64'd0);
    chk("idle addr hold", 64'(wr_addr1), 64'd40);
    chk("idle data hold", 64'(wr_data1), 64'hDEADBEEF);
    chk("idle rr_ptr hold", 64'(rr_ptr), 64'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
